// File: rtl/int_ctrl_if.sv
// Handshake and SFR-side signal bundle for int_ctrl.
// The master is the CPU/SFR side. The slave is the controller.
interface int_ctrl_if #(
  parameter int NSRC  = 5,
  parameter int VEC_W = 16
);
  logic             ea;
  logic [NSRC-1:0]  ie;
  logic [NSRC-1:0]  ip;
  logic [NSRC-1:0]  flag;
  logic             int_ack;
  logic             reti;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [NSRC-1:0]  int_src;
  logic [NSRC-1:0]  flag_clr;
  logic [1:0]       isr_act;

  modport master (
    output ea, ie, ip, flag, int_ack, reti,
    input  int_req, int_vec, int_src, flag_clr, isr_act
  );

  modport slave (
    input  ea, ie, ip, flag, int_ack, reti,
    output int_req, int_vec, int_src, flag_clr, isr_act
  );
endinterface

// File: rtl/int_ctrl.sv
// 8051-style interrupt controller for NSRC sources, with a registered request/ack handshake.
// Define INT_CTRL_PRIO2_EN to enable two priority levels with nesting. The default is one level with no nesting.
module int_ctrl #(
  parameter int               NSRC       = 5,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = 'h0003,
  parameter int               VEC_STRIDE = 8,
  parameter logic [NSRC-1:0]  AUTOCLR    = 5'b01111
) (
  input  logic      clk,
  input  logic      rst,
  int_ctrl_if.slave bus
);

  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t           state;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [NSRC-1:0]  int_src;
  logic [NSRC-1:0]  flag_clr;
  logic [1:0]       isr_act;
  logic [IDX_W-1:0] req_idx;
  logic             req_lvl;

  logic [NSRC-1:0]  cand;
  logic [NSRC-1:0]  cand_hi;
  logic [NSRC-1:0]  cand_lo;
  logic [NSRC-1:0]  elig;
  logic             hi_ok;
  logic             lo_ok;
  logic             win_hi;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             still_ok;
  logic             reti_ok;

  function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    int unsigned sum;
    sum = int'(VEC_BASE) + int'(idx) * VEC_STRIDE;
    return VEC_W'(sum);
  endfunction

  // RETI retires the most recent (highest) active level.
  function automatic logic [1:0] isr_after_reti(input logic [1:0] act);
    return act[1] ? {1'b0, act[0]} : 2'b00;
  endfunction

  always_comb begin
    cand = bus.flag & bus.ie & {NSRC{bus.ea}};
`ifdef INT_CTRL_PRIO2_EN
    cand_hi = cand & bus.ip;
`else
    cand_hi = '0;
`endif
    cand_lo  = cand & ~cand_hi;
    hi_ok    = !isr_act[1];
    lo_ok    = (isr_act == 2'b00);
    win_hi   = hi_ok && (|cand_hi);
    elig     = win_hi ? cand_hi : (lo_ok ? cand_lo : '0);
    win_vld  = 1'b0;
    win_idx  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    still_ok = cand[req_idx] && (req_lvl ? hi_ok : lo_ok);
    reti_ok  = bus.reti && (isr_act != 2'b00);
  end

  // The HOLD exit edge arbitrates as IDLE does. A request pending across RETI therefore
  // appears in the cycle right after the one instruction that HOLD lets execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      int_req  <= 1'b0;
      int_vec  <= '0;
      int_src  <= '0;
      flag_clr <= '0;
      isr_act  <= 2'b00;
      req_idx  <= '0;
      req_lvl  <= 1'b0;
    end else begin
      flag_clr <= '0;
      case (state)
        REQ: begin
          if (bus.int_ack) begin
            isr_act[req_lvl] <= 1'b1;
            flag_clr         <= AUTOCLR & int_src;
            int_req          <= 1'b0;
            int_vec          <= '0;
            int_src          <= '0;
            state            <= IDLE;
          end else if (reti_ok) begin
            isr_act <= isr_after_reti(isr_act);
            int_req <= 1'b0;
            int_vec <= '0;
            int_src <= '0;
            state   <= HOLD;
          end else if (!still_ok) begin
            int_req <= 1'b0;
            int_vec <= '0;
            int_src <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          if (reti_ok) begin
            isr_act <= isr_after_reti(isr_act);
            state   <= HOLD;
          end else if (win_vld) begin
            int_req <= 1'b1;
            int_vec <= vec_of(win_idx);
            int_src <= NSRC'(1) << win_idx;
            req_idx <= win_idx;
            req_lvl <= win_hi;
            state   <= REQ;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.int_req  = int_req;
  assign bus.int_vec  = int_vec;
  assign bus.int_src  = int_src;
  assign bus.flag_clr = flag_clr;
  assign bus.isr_act  = isr_act;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller for the 8051 core. It generalises the fixed five-source arbiter to NSRC sources with two 8051-style priority levels (IP) and nesting. It tracks in-service state and computes the service vector. A registered request/acknowledge handshake with the CPU sequencer replaces the purely combinational decision. The block sits between the SFR file (IE, IP, flag bits) and the instruction-fetch control that injects the hardware LCALL.

## Interface
- NSRC, 5, number of interrupt sources; index 0 is the highest natural priority.
- VEC_W, 16, vector address width.
- VEC_BASE, 16'h0003, vector of source 0.
- VEC_STRIDE, 8, address distance between consecutive source vectors.
- AUTOCLR, 5'b01111, per-source mask: 1 means hardware clears the source flag on acknowledge.
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ea  input  1  global enable (IE.7).
- ie  input  NSRC  per-source enable.
- ip  input  NSRC  per-source priority; 1 means high.
- flag  input  NSRC  pending flags (TF/IE bits; RI|TI pre-ORed by the SFR file).
- int_ack  input  1  one-cycle pulse from the CPU; accepts the current request.
- reti  input  1  one-cycle pulse; a RETI instruction has executed.
- int_req  output  1  interrupt request to the CPU.
- int_vec  output  VEC_W  vector for the current request; valid while int_req=1.
- int_src  output  NSRC  one-hot source of the current request.
- flag_clr  output  NSRC  one-cycle pulse; clears the acknowledged flag in the SFR file.
- isr_act  output  2  in-service bits, {high, low}.

## Operation
- cand = flag & ie & {NSRC{ea}}. cand_hi = cand & ip. cand_lo = cand & ~ip.
- Eligible set:
  - cand_hi if isr_act[1]=0.
  - Otherwise cand_lo if isr_act=2'b00.
  - Otherwise none.
  - High preempts low; equal or lower level never preempts.
- Winner: the lowest set index of the eligible set. int_vec = VEC_BASE + idx*VEC_STRIDE, truncated to VEC_W.
- States:
  - IDLE: when a winner exists, register int_req=1, int_vec, int_src and the winner's level, then go to REQ.
  - REQ:
    - int_ack=1: go to IDLE. Set isr_act[level]. Pulse flag_clr[idx] if AUTOCLR[idx]. Drop int_req.
    - The latched source is no longer eligible (flag cleared, ie/ea dropped, or preempting level blocked): withdraw. int_req=0, go to IDLE, no clear.
    - A higher-priority source becoming eligible does not replace the latched request before ack.
  - HOLD: entered for exactly one cycle after reti. No request is raised, so one instruction executes after RETI. Then go to IDLE.
- reti clears isr_act[1] if set, else isr_act[0]. reti with isr_act=0 is ignored.
- int_ack outside REQ is ignored. Sources with AUTOCLR=0 (serial) are cleared by software only.

## Timing
- Reset values:
  - State IDLE.
  - int_req=0, int_vec=0, int_src=0, flag_clr=0, isr_act=2'b00.
- Request latency: a flag that is eligible at edge N gives int_req=1 after edge N+1 (registered).
- Ack: flag_clr pulses and isr_act updates in the cycle after the edge that samples int_ack. int_req is 0 in that same cycle.
- Simultaneous reti and int_ack in one cycle: ack is processed and reti is ignored (the CPU never issues both).
- flag_clr and the SFR write of the same flag in one cycle: the SFR file gives flag_clr priority.
- Reset asserted mid-handshake returns to reset values immediately (asynchronous); pending flags re-request after release.

## Configuration
- INT_CTRL_PRIO2_EN defined: two-level priority and nesting, as described above.
- INT_CTRL_PRIO2_EN undefined:
  - ip is ignored and every source is low.
  - isr_act[1] is tied 0.
  - No nesting: no request while isr_act[0]=1.

## Test plan
- flag=5'b00110, ie=5'b11111, ea=1, ip=0 -> int_req next cycle, int_src=5'b00010, int_vec=16'h000B. Ack -> flag_clr=5'b00010, isr_act=2'b01.
- Source 4 (serial) pending and acknowledged -> int_vec=16'h0023, flag_clr=0.
- Low ISR active, then flag[3] with ip[3]=1 -> request, int_vec=16'h001B. Ack -> isr_act=2'b11. First reti -> 2'b01. Second reti -> 2'b00.
- In REQ for source 0, ea dropped before ack -> int_req=0 next cycle, no flag_clr pulse.
- reti with a flag still pending -> int_req stays 0 for the HOLD cycle and asserts one cycle later.
- rst pulsed while in REQ -> all outputs 0 immediately. After release, the pending flag re-requests after 1 cycle.
